// File: rtl/sbox_lane_sched.sv
// sbox_lane_sched
// One 32-bit lane of four AES forward S-boxes, time-shared between a 128-bit
// state SubBytes request (four lane cycles) and a 32-bit key SubWord request
// (one lane cycle). Simultaneous requests alternate, starting with KEY_FIRST.
//
// Ports
//   i_clk       rising-edge clock
//   i_reset     asynchronous active-high reset
//   i_st_req    state SubBytes request (level, sampled in idle only)
//   i_st_in     state to substitute, captured on the accept edge
//   o_st_grant  one-cycle pulse after i_st_in is captured
//   o_st_done   one-cycle pulse, o_st_out new in this cycle
//   o_st_out    substituted state, held until the next o_st_done
//   i_kw_req    key SubWord request (level, sampled in idle only)
//   i_kw_in     key word, captured on the accept edge
//   o_kw_grant  one-cycle pulse after i_kw_in is captured
//   o_kw_done   one-cycle pulse, o_kw_out new in this cycle
//   o_kw_out    substituted word, held until the next o_kw_done
//   o_busy      high whenever the scheduler is not idle
module sbox_lane_sched #(
  parameter bit KEY_FIRST = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_st_req,
  input  logic [127:0] i_st_in,
  output logic         o_st_grant,
  output logic         o_st_done,
  output logic [127:0] o_st_out,
  input  logic         i_kw_req,
  input  logic [31:0]  i_kw_in,
  output logic         o_kw_grant,
  output logic         o_kw_done,
  output logic [31:0]  o_kw_out,
  output logic         o_busy
);

  typedef enum logic [1:0] {Idle, StRun, KwRun} state_e;

  // AES forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_byte(input logic [7:0] b);
    return SboxTable[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = sbox_byte(w[8*i +: 8]);
    end
    return r;
  endfunction

  state_e       r_state;
  logic [1:0]   r_cnt;
  logic [127:0] r_st_buf;
  logic [31:0]  r_kw_buf;
  logic [95:0]  r_acc;
  logic [127:0] r_st_out;
  logic [31:0]  r_kw_out;
  logic         r_st_grant;
  logic         r_kw_grant;
  logic         r_st_done;
  logic         r_kw_done;
  logic         r_last_key;

  logic [31:0]  w_lane_in;
  logic [31:0]  w_lane_out;
  logic         w_pick_key;
  logic         w_pick_st;

  // Single shared lane: state word cnt while substituting the state, else the key word.
  always_comb begin
    w_lane_in = r_kw_buf;
    if (r_state == StRun) begin
      w_lane_in = r_st_buf[{r_cnt, 5'b0} +: 32];
    end
    w_lane_out = sub_word(w_lane_in);
  end

  // On conflict the requester not served last wins.
  assign w_pick_key = i_kw_req & (~i_st_req | ~r_last_key);
  assign w_pick_st  = i_st_req & ~w_pick_key;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= Idle;
      r_cnt      <= 2'd0;
      r_st_buf   <= '0;
      r_kw_buf   <= '0;
      r_acc      <= '0;
      r_st_out   <= '0;
      r_kw_out   <= '0;
      r_st_grant <= 1'b0;
      r_kw_grant <= 1'b0;
      r_st_done  <= 1'b0;
      r_kw_done  <= 1'b0;
      r_last_key <= ~KEY_FIRST;
    end else begin
      r_st_grant <= 1'b0;
      r_kw_grant <= 1'b0;
      r_st_done  <= 1'b0;
      r_kw_done  <= 1'b0;
      unique case (r_state)
        Idle: begin
          if (w_pick_key) begin
            r_kw_buf   <= i_kw_in;
            r_kw_grant <= 1'b1;
            r_last_key <= 1'b1;
            r_state    <= KwRun;
          end else if (w_pick_st) begin
            r_st_buf   <= i_st_in;
            r_cnt      <= 2'd0;
            r_st_grant <= 1'b1;
            r_last_key <= 1'b0;
            r_state    <= StRun;
          end
        end
        StRun: begin
          unique case (r_cnt)
            2'd0: r_acc[31:0]  <= w_lane_out;
            2'd1: r_acc[63:32] <= w_lane_out;
            2'd2: r_acc[95:64] <= w_lane_out;
            2'd3: begin
              // Whole state published at once so st_out never shows partial words.
              r_st_out  <= {w_lane_out, r_acc};
              r_st_done <= 1'b1;
              r_state   <= Idle;
            end
            default: ;
          endcase
          r_cnt <= r_cnt + 2'd1;
        end
        KwRun: begin
          r_kw_out  <= w_lane_out;
          r_kw_done <= 1'b1;
          r_state   <= Idle;
        end
        default: r_state <= Idle;
      endcase
    end
  end

  assign o_st_grant = r_st_grant;
  assign o_st_done  = r_st_done;
  assign o_st_out   = r_st_out;
  assign o_kw_grant = r_kw_grant;
  assign o_kw_done  = r_kw_done;
  assign o_kw_out   = r_kw_out;
  assign o_busy     = (r_state != Idle);

endmodule

// File: tb/tb_sbox_lane_sched.sv
module tb_sbox_lane_sched;

  localparam logic [127:0] StV0  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] StE0  = 128'h76abd7fe2b670130c56f6bf27b777c63;
  localparam logic [127:0] StV1  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] StE1  = 128'h1628c14beaaceec4f533fc1bc3938263;
  localparam logic [127:0] StV2  = {16{8'h53}};
  localparam logic [127:0] StE2  = {16{8'hed}};
  localparam logic [127:0] StE3  = {16{8'h63}};

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         st_req = 1'b0;
  logic [127:0] st_in  = '0;
  logic         kw_req = 1'b0;
  logic [31:0]  kw_in  = '0;
  logic         st_grant, st_done, kw_grant, kw_done, busy;
  logic [127:0] st_out;
  logic [31:0]  kw_out;

  logic         b_st_req = 1'b0;
  logic [127:0] b_st_in  = '0;
  logic         b_kw_req = 1'b0;
  logic [31:0]  b_kw_in  = '0;
  logic         b_st_grant, b_st_done, b_kw_grant, b_kw_done, b_busy;
  logic [127:0] b_st_out;
  logic [31:0]  b_kw_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sbox_lane_sched #(.KEY_FIRST(1'b1)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_st_req(st_req), .i_st_in(st_in), .o_st_grant(st_grant), .o_st_done(st_done),
    .o_st_out(st_out),
    .i_kw_req(kw_req), .i_kw_in(kw_in), .o_kw_grant(kw_grant), .o_kw_done(kw_done),
    .o_kw_out(kw_out), .o_busy(busy)
  );

  sbox_lane_sched #(.KEY_FIRST(1'b0)) dut_b (
    .i_clk(clk), .i_reset(rst),
    .i_st_req(b_st_req), .i_st_in(b_st_in), .o_st_grant(b_st_grant), .o_st_done(b_st_done),
    .o_st_out(b_st_out),
    .i_kw_req(b_kw_req), .i_kw_in(b_kw_in), .o_kw_grant(b_kw_grant), .o_kw_done(b_kw_done),
    .o_kw_out(b_kw_out), .o_busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_ctl"}, {123'd0, st_grant, st_done, kw_grant, kw_done, busy}, '0);
    check_eq({tag, "_st_out"}, st_out, '0);
    check_eq({tag, "_kw_out"}, {96'd0, kw_out}, '0);
  endtask

  task automatic run_st(input string tag, input logic [127:0] din, input logic [127:0] exp);
    logic [31:0] kw_before;
    int lat;
    int busy_n;
    bit seen;
    kw_before = kw_out;
    st_req = 1'b1;
    st_in  = din;
    tick();
    check_eq({tag, "_grant"}, {127'd0, st_grant}, 128'd1);
    st_req = 1'b0;
    st_in  = '0;
    lat    = 0;
    busy_n = int'(busy);
    seen   = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      lat++;
      busy_n += int'(busy);
      if (st_done) seen = 1'b1;
    end
    check_eq({tag, "_latency"}, 128'(lat), 128'd4);
    check_eq({tag, "_busy_cycles"}, 128'(busy_n), 128'd4);
    check_eq({tag, "_st_out"}, st_out, exp);
    check_eq({tag, "_kw_kept"}, {96'd0, kw_out}, {96'd0, kw_before});
    tick();
    check_eq({tag, "_done_pulse"}, {127'd0, st_done}, 128'd0);
  endtask

  task automatic run_kw(input string tag, input logic [31:0] din, input logic [31:0] exp);
    logic [127:0] st_before;
    int lat;
    bit seen;
    st_before = st_out;
    kw_req = 1'b1;
    kw_in  = din;
    tick();
    check_eq({tag, "_grant"}, {127'd0, kw_grant}, 128'd1);
    check_eq({tag, "_busy"}, {127'd0, busy}, 128'd1);
    kw_req = 1'b0;
    kw_in  = '0;
    lat    = 0;
    seen   = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      lat++;
      if (kw_done) seen = 1'b1;
    end
    check_eq({tag, "_latency"}, 128'(lat), 128'd1);
    check_eq({tag, "_kw_out"}, {96'd0, kw_out}, {96'd0, exp});
    check_eq({tag, "_st_kept"}, st_out, st_before);
    check_eq({tag, "_idle"}, {127'd0, busy}, 128'd0);
  endtask

  initial begin
    int early;
    int done_n;
    int seq_a;
    int seq_b;
    int na;
    int nb;
    bit seen;

    // Reset state
    rst = 1'b1;
    tick();
    check_idle_zero("reset");
    rst = 1'b0;
    tick();

    // Directed vectors
    run_st("st_vec0", StV0, StE0);
    run_kw("kw_vec0", 32'hcf4f3c09, 32'h8a84eb01);
    run_st("st_zero", '0, StE3);
    run_kw("kw_zero", 32'h00000000, 32'h63636363);
    run_st("st_vec1", StV1, StE1);
    run_st("st_53", StV2, StE2);
    run_kw("kw_vec0b", 32'hcf4f3c09, 32'h8a84eb01);

    // Last accept was a key: a conflict now goes to the state requester
    st_req = 1'b1;
    kw_req = 1'b1;
    st_in  = StV0;
    kw_in  = 32'h11111111;
    tick();
    check_eq("lastsrv_st_grant", {127'd0, st_grant}, 128'd1);
    check_eq("lastsrv_kw_grant", {127'd0, kw_grant}, 128'd0);
    st_req = 1'b0;
    kw_req = 1'b0;
    repeat (8) tick();

    // Key request raised mid state op waits for st_done
    st_req = 1'b1;
    st_in  = StV1;
    tick();
    st_req = 1'b0;
    tick();
    kw_req = 1'b1;
    kw_in  = 32'hffffffff;
    early  = 0;
    seen   = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (st_done) seen = 1'b1;
      else begin
        early += int'(kw_grant);
        tick();
      end
    end
    check_eq("wait_no_early_kw_grant", 128'(early), 128'd0);
    check_eq("wait_st_done", {127'd0, st_done}, 128'd1);
    check_eq("wait_st_out", st_out, StE1);
    check_eq("wait_kw_grant_at_done", {127'd0, kw_grant}, 128'd0);
    tick();
    check_eq("wait_kw_grant_next", {127'd0, kw_grant}, 128'd1);
    kw_req = 1'b0;
    tick();
    check_eq("wait_kw_done", {127'd0, kw_done}, 128'd1);
    check_eq("wait_kw_out", {96'd0, kw_out}, {96'd0, 32'h16161616});
    tick();

    // Reset at cnt==2 aborts the op
    st_req = 1'b1;
    st_in  = StV2;
    tick();
    st_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_idle_zero("midreset");
    tick();
    rst    = 1'b0;
    done_n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      done_n += int'(st_done);
    end
    check_eq("midreset_no_done", 128'(done_n), 128'd0);
    run_st("after_reset", StV0, StE0);

    // Held conflicting requests from reset: alternation, order set by KEY_FIRST
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    st_req   = 1'b1;
    kw_req   = 1'b1;
    st_in    = StV0;
    kw_in    = 32'hcf4f3c09;
    b_st_req = 1'b1;
    b_kw_req = 1'b1;
    b_st_in  = StV0;
    b_kw_in  = 32'hcf4f3c09;
    seq_a = 0;
    seq_b = 0;
    na    = 0;
    nb    = 0;
    for (int i = 0; i < 40 && (na < 3 || nb < 3); i++) begin
      tick();
      if (na < 3 && (kw_grant || st_grant)) begin
        seq_a = seq_a * 4 + (kw_grant ? 1 : 2);
        na++;
        if (na == 3) begin
          st_req = 1'b0;
          kw_req = 1'b0;
        end
      end
      if (nb < 3 && (b_kw_grant || b_st_grant)) begin
        seq_b = seq_b * 4 + (b_kw_grant ? 1 : 2);
        nb++;
        if (nb == 3) begin
          b_st_req = 1'b0;
          b_kw_req = 1'b0;
        end
      end
    end
    st_req   = 1'b0;
    kw_req   = 1'b0;
    b_st_req = 1'b0;
    b_kw_req = 1'b0;
    // K,S,K encodes to 25; S,K,S encodes to 38
    check_eq("alt_key_first_order", 128'(seq_a), 128'd25);
    check_eq("alt_state_first_order", 128'(seq_b), 128'd38);
    repeat (8) tick();
    check_eq("alt_a_st_out", st_out, StE0);
    check_eq("alt_a_kw_out", {96'd0, kw_out}, {96'd0, 32'h8a84eb01});
    check_eq("alt_b_st_out", b_st_out, StE0);
    check_eq("alt_b_kw_out", {96'd0, b_kw_out}, {96'd0, 32'h8a84eb01});
    check_eq("alt_idle", {126'd0, busy, b_busy}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
